// File: rtl/addr_map_engine.sv
// Programmable two-stage SNES->SRAM address mapper with shadow/active window sets.
// Stage 1 matches the captured address against the active windows; stage 2 resolves priority and translates.
module addr_map_engine #(
    parameter int NUM_WIN   = 8,
    parameter int IDX_W     = 3,
    parameter int FEAT_MSU1 = 3,
    parameter int FEAT_213F = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [7:0]       featurebits,
    input  logic [23:0]      SNES_ADDR,
    input  logic [7:0]       SNES_PA,
    input  logic             SNES_REQ,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_win,
    input  logic [2:0]       cfg_field,
    input  logic [23:0]      cfg_data,
    input  logic             cfg_commit,
    output logic             cfg_busy,
    output logic             MAP_VALID,
    output logic             MAP_MISS,
    output logic [IDX_W-1:0] MAP_WIN,
    output logic [23:0]      ROM_ADDR,
    output logic             ROM_HIT,
    output logic             RAM_HIT,
    output logic             IS_ROM,
    output logic             IS_SAVERAM,
    output logic             IS_WRITABLE,
    output logic             msu_enable,
    output logic             r213f_enable
);

    logic [23:0] r_sh_match [NUM_WIN];
    logic [23:0] r_sh_mmask [NUM_WIN];
    logic [23:0] r_sh_pbase [NUM_WIN];
    logic [23:0] r_sh_pmask [NUM_WIN];
    logic [4:0]  r_sh_attr  [NUM_WIN];
    logic [23:0] r_ac_match [NUM_WIN];
    logic [23:0] r_ac_mmask [NUM_WIN];
    logic [23:0] r_ac_pbase [NUM_WIN];
    logic [23:0] r_ac_pmask [NUM_WIN];
    logic [4:0]  r_ac_attr  [NUM_WIN];
    logic        r_pending;

    logic               r_vld_p1;
    logic [23:0]        r_addr_p1;
    logic [NUM_WIN-1:0] r_hit_p1;
    logic               r_msu_p1;
    logic               r_213f_p1;

    logic               r_vld_p2;
    logic               r_miss_p2;
    logic [IDX_W-1:0]   r_win_p2;
    logic [23:0]        r_addr_p2;
    logic               r_rom_p2;
    logic               r_ram_p2;
    logic               r_isrom_p2;
    logic               r_save_p2;
    logic               r_wr_p2;
    logic               r_msu_p2;
    logic               r_213f_p2;

    logic [NUM_WIN-1:0] w_hit;
    logic               w_msu;
    logic               w_213f;
    logic               w_any;
    logic [IDX_W-1:0]   w_win;
    logic [4:0]         w_attr;
    logic [23:0]        w_off;
    logic [23:0]        w_xlat;
    logic               w_cfg_ok;

    assign w_cfg_ok = !r_pending && (int'(cfg_win) < NUM_WIN);

    // Commit waits for a gap so no request straddles the old and new window sets.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pending <= 1'b0;
            for (int i = 0; i < NUM_WIN; i++) begin
                r_sh_match[i] <= '0;
                r_sh_mmask[i] <= '0;
                r_sh_pbase[i] <= '0;
                r_sh_pmask[i] <= '0;
                r_sh_attr[i]  <= '0;
                r_ac_match[i] <= '0;
                r_ac_mmask[i] <= '0;
                r_ac_pbase[i] <= '0;
                r_ac_pmask[i] <= '0;
                r_ac_attr[i]  <= '0;
            end
        end else begin
            if (cfg_we && w_cfg_ok) begin
                case (cfg_field)
                    3'd0:    r_sh_match[cfg_win] <= cfg_data;
                    3'd1:    r_sh_mmask[cfg_win] <= cfg_data;
                    3'd2:    r_sh_pbase[cfg_win] <= cfg_data;
                    3'd3:    r_sh_pmask[cfg_win] <= cfg_data;
                    3'd4:    r_sh_attr[cfg_win]  <= cfg_data[4:0];
                    default: ;
                endcase
            end
            if (cfg_commit && !r_pending) begin
                r_pending <= 1'b1;
            end else if (r_pending && !SNES_REQ && !r_vld_p1) begin
                r_pending <= 1'b0;
                for (int i = 0; i < NUM_WIN; i++) begin
                    r_ac_match[i] <= r_sh_match[i];
                    r_ac_mmask[i] <= r_sh_mmask[i];
                    r_ac_pbase[i] <= r_sh_pbase[i];
                    r_ac_pmask[i] <= r_sh_pmask[i];
                    r_ac_attr[i]  <= r_sh_attr[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_WIN; i++) begin
            w_hit[i] = r_ac_attr[i][0] && (((SNES_ADDR ^ r_ac_match[i]) & r_ac_mmask[i]) == 24'h0);
        end
    end

    assign w_msu  = featurebits[FEAT_MSU1] && !SNES_ADDR[22] && (SNES_ADDR[15:3] == 13'h0400);
    assign w_213f = featurebits[FEAT_213F] && (SNES_PA == 8'h3f);

    // Stage 1: capture address, hit vector and peripheral decode.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_vld_p1  <= 1'b0;
            r_addr_p1 <= '0;
            r_hit_p1  <= '0;
            r_msu_p1  <= 1'b0;
            r_213f_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= SNES_REQ;
            if (SNES_REQ) begin
                r_addr_p1 <= SNES_ADDR;
                r_hit_p1  <= w_hit;
                r_msu_p1  <= w_msu;
                r_213f_p1 <= w_213f;
            end
        end
    end

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (r_hit_p1[i]) begin
                w_any = 1'b1;
                w_win = i[IDX_W-1:0];
            end
        end
    end

    assign w_attr = r_ac_attr[w_win];
    assign w_off  = w_attr[4] ? {1'b0, r_addr_p1[23:16], r_addr_p1[14:0]} : r_addr_p1;
    assign w_xlat = r_ac_pbase[w_win] | (w_off & r_ac_pmask[w_win]);

    // Stage 2: priority resolve, translate, register results (held until next valid).
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_vld_p2   <= 1'b0;
            r_miss_p2  <= 1'b0;
            r_win_p2   <= '0;
            r_addr_p2  <= '0;
            r_rom_p2   <= 1'b0;
            r_ram_p2   <= 1'b0;
            r_isrom_p2 <= 1'b0;
            r_save_p2  <= 1'b0;
            r_wr_p2    <= 1'b0;
            r_msu_p2   <= 1'b0;
            r_213f_p2  <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_msu_p2  <= r_msu_p1;
                r_213f_p2 <= r_213f_p1;
                if (w_any) begin
                    r_miss_p2  <= 1'b0;
                    r_win_p2   <= w_win;
                    r_addr_p2  <= w_xlat;
                    r_rom_p2   <= !w_attr[1];
                    r_ram_p2   <= w_attr[1];
                    r_isrom_p2 <= !w_attr[1] && !w_attr[2];
                    r_save_p2  <= w_attr[3];
                    r_wr_p2    <= w_attr[2] || w_attr[3];
                end else begin
                    r_miss_p2  <= 1'b1;
                    r_win_p2   <= '0;
                    r_addr_p2  <= r_addr_p1;
                    r_rom_p2   <= 1'b0;
                    r_ram_p2   <= 1'b0;
                    r_isrom_p2 <= 1'b0;
                    r_save_p2  <= 1'b0;
                    r_wr_p2    <= 1'b0;
                end
            end
        end
    end

    assign cfg_busy     = r_pending;
    assign MAP_VALID    = r_vld_p2;
    assign MAP_MISS     = r_miss_p2;
    assign MAP_WIN      = r_win_p2;
    assign ROM_ADDR     = r_addr_p2;
    assign ROM_HIT      = r_rom_p2;
    assign RAM_HIT      = r_ram_p2;
    assign IS_ROM       = r_isrom_p2;
    assign IS_SAVERAM   = r_save_p2;
    assign IS_WRITABLE  = r_wr_p2;
    assign msu_enable   = r_msu_p2;
    assign r213f_enable = r_213f_p2;

endmodule

// File: tb/tb_addr_map_engine.sv
// Self-checking bench for addr_map_engine: vector table plus scoreboard of expected map results.
module tb_addr_map_engine;

    typedef struct packed {
        logic        miss;
        logic [2:0]  win;
        logic [23:0] addr;
        logic        rom;
        logic        ram;
        logic        isrom;
        logic        save;
        logic        wr;
        logic        msu;
        logic        r213f;
    } exp_t;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  pa;
        logic [7:0]  feat;
        exp_t        exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  featurebits = '0;
    logic [23:0] SNES_ADDR = '0;
    logic [7:0]  SNES_PA = '0;
    logic        SNES_REQ = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_win = '0;
    logic [2:0]  cfg_field = '0;
    logic [23:0] cfg_data = '0;
    logic        cfg_commit = 1'b0;
    logic        cfg_busy, MAP_VALID, MAP_MISS, ROM_HIT, RAM_HIT;
    logic        IS_ROM, IS_SAVERAM, IS_WRITABLE, msu_enable, r213f_enable;
    logic [2:0]  MAP_WIN;
    logic [23:0] ROM_ADDR;

    addr_map_engine dut (
        .CLK(CLK), .RST_N(RST_N), .featurebits(featurebits), .SNES_ADDR(SNES_ADDR),
        .SNES_PA(SNES_PA), .SNES_REQ(SNES_REQ), .cfg_we(cfg_we), .cfg_win(cfg_win),
        .cfg_field(cfg_field), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cfg_busy(cfg_busy), .MAP_VALID(MAP_VALID), .MAP_MISS(MAP_MISS), .MAP_WIN(MAP_WIN),
        .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .RAM_HIT(RAM_HIT), .IS_ROM(IS_ROM),
        .IS_SAVERAM(IS_SAVERAM), .IS_WRITABLE(IS_WRITABLE), .msu_enable(msu_enable),
        .r213f_enable(r213f_enable)
    );

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t last = '0;

    logic [23:0] s_match [8], s_mmask [8], s_pbase [8], s_pmask [8];
    logic [4:0]  s_attr  [8];
    logic [23:0] m_match [8], m_mmask [8], m_pbase [8], m_pmask [8];
    logic [4:0]  m_attr  [8];

    function automatic exp_t mk(input logic miss, input logic [2:0] win, input logic [23:0] addr,
                                input logic rom, input logic ram, input logic isrom,
                                input logic save, input logic wr, input logic msu, input logic r213f);
        exp_t e;
        e.miss = miss; e.win = win; e.addr = addr; e.rom = rom; e.ram = ram;
        e.isrom = isrom; e.save = save; e.wr = wr; e.msu = msu; e.r213f = r213f;
        return e;
    endfunction

    function automatic exp_t model(input logic [23:0] a, input logic [7:0] pa, input logic [7:0] f);
        exp_t        e;
        int          w;
        logic [23:0] off;
        w = -1;
        e = '0;
        for (int i = 0; i < 8; i++)
            if (w < 0 && m_attr[i][0] && (((a ^ m_match[i]) & m_mmask[i]) == 24'h0)) w = i;
        e.msu   = f[3] && !a[22] && (a[15:3] == 13'h0400);
        e.r213f = f[4] && (pa == 8'h3f);
        if (w < 0) begin
            e.miss = 1'b1;
            e.addr = a;
        end else begin
            off     = m_attr[w][4] ? {1'b0, a[23:16], a[14:0]} : a;
            e.win   = w[2:0];
            e.addr  = m_pbase[w] | (off & m_pmask[w]);
            e.ram   = m_attr[w][1];
            e.rom   = !m_attr[w][1];
            e.isrom = !m_attr[w][1] && !m_attr[w][2];
            e.save  = m_attr[w][3];
            e.wr    = m_attr[w][2] || m_attr[w][3];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    function automatic exp_t actual();
        return mk(MAP_MISS, MAP_WIN, ROM_ADDR, ROM_HIT, RAM_HIT, IS_ROM, IS_SAVERAM,
                  IS_WRITABLE, msu_enable, r213f_enable);
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge CLK);
        #1;
        if (MAP_VALID) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got MAP_VALID=1 required 0");
            end else begin
                e = q.pop_front();
                chk("map_result", 64'(actual()), 64'(e));
                last = e;
            end
        end else begin
            chk("hold_outputs", 64'(actual()), 64'(last));
        end
    endtask

    task automatic send(input logic [23:0] a, input logic [7:0] pa, input logic [7:0] f, input exp_t e);
        SNES_REQ = 1'b1; SNES_ADDR = a; SNES_PA = pa; featurebits = f;
        q.push_back(e);
        tick();
        SNES_REQ = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] w, input logic [2:0] fld, input logic [23:0] d);
        cfg_we = 1'b1; cfg_win = w; cfg_field = fld; cfg_data = d;
        tick();
        cfg_we = 1'b0;
        case (fld)
            3'd0: s_match[w] = d;
            3'd1: s_mmask[w] = d;
            3'd2: s_pbase[w] = d;
            3'd3: s_pmask[w] = d;
            3'd4: s_attr[w]  = d[4:0];
            default: ;
        endcase
    endtask

    task automatic win_cfg(input logic [2:0] w, input logic [23:0] mt, input logic [23:0] mm,
                           input logic [23:0] pb, input logic [23:0] pm, input logic [4:0] at);
        cfg_write(w, 3'd0, mt);
        cfg_write(w, 3'd1, mm);
        cfg_write(w, 3'd2, pb);
        cfg_write(w, 3'd3, pm);
        cfg_write(w, 3'd4, {19'h0, at});
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("busy_after_commit", 64'(cfg_busy), 64'd1);
        tick();
        chk("busy_cleared", 64'(cfg_busy), 64'd0);
        for (int i = 0; i < 8; i++) begin
            m_match[i] = s_match[i]; m_mmask[i] = s_mmask[i]; m_pbase[i] = s_pbase[i];
            m_pmask[i] = s_pmask[i]; m_attr[i]  = s_attr[i];
        end
    endtask

    vec_t tbl [8];
    logic [23:0] burst [10];

    initial begin
        for (int i = 0; i < 8; i++) begin
            s_match[i] = '0; s_mmask[i] = '0; s_pbase[i] = '0; s_pmask[i] = '0; s_attr[i] = '0;
            m_match[i] = '0; m_mmask[i] = '0; m_pbase[i] = '0; m_pmask[i] = '0; m_attr[i] = '0;
        end
        tbl[0] = '{24'h01FFFF, 8'h00, 8'h00, mk(0, 0, 24'h00FFFF, 1, 0, 1, 0, 0, 0, 0)};
        tbl[1] = '{24'h791234, 8'h00, 8'h00, mk(0, 1, 24'hE11234, 1, 0, 0, 1, 1, 0, 0)};
        tbl[2] = '{24'h700010, 8'h00, 8'h00, mk(0, 2, 24'h100010, 0, 1, 0, 0, 0, 0, 0)};
        tbl[3] = '{24'h002003, 8'h3f, 8'h18, mk(1, 0, 24'h002003, 0, 0, 0, 0, 0, 1, 1)};
        tbl[4] = '{24'hC00000, 8'h3f, 8'h08, mk(1, 0, 24'hC00000, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5] = '{24'h00C123, 8'h3e, 8'h08, mk(0, 0, 24'h004123, 1, 0, 1, 0, 0, 0, 0)};
        tbl[6] = '{24'h79FFFF, 8'h00, 8'h00, mk(0, 1, 24'hE1FFFF, 1, 0, 0, 1, 1, 0, 0)};
        tbl[7] = '{24'h70FFFF, 8'h00, 8'h00, mk(0, 2, 24'h10FFFF, 0, 1, 0, 0, 0, 0, 0)};
        burst = '{24'h700010, 24'h01FFFF, 24'h791234, 24'h700010, 24'hC00000,
                  24'h00C123, 24'h700010, 24'h79FFFF, 24'h123456, 24'h700010};

        // Reset state and a miss on disabled windows.
        repeat (3) tick();
        chk("reset_busy", 64'(cfg_busy), 64'd0);
        RST_N = 1'b1;
        tick();
        send(24'h008000, 8'h00, 8'h00, mk(1, 0, 24'h008000, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();

        win_cfg(3'd0, 24'h008000, 24'hC08000, 24'h000000, 24'h1FFFFF, 5'h11);
        commit();
        win_cfg(3'd1, 24'h780000, 24'hFE0000, 24'hE00000, 24'h01FFFF, 5'h0D);
        win_cfg(3'd2, 24'h700000, 24'hFF0000, 24'h100000, 24'h00FFFF, 5'h03);
        win_cfg(3'd5, 24'h700010, 24'hFFFFFF, 24'h0A0000, 24'h00FFFF, 5'h01);
        commit();

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].addr, tbl[i].pa, tbl[i].feat, tbl[i].exp);
            tick();
            tick();
        end

        // Disable win2 in shadow only, then commit during a continuous burst.
        cfg_write(3'd2, 3'd4, 24'h0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) cfg_commit = 1'b1;
            if (i == 5) begin
                cfg_we = 1'b1; cfg_win = 3'd0; cfg_field = 3'd4; cfg_data = 24'h0;
            end
            send(burst[i], 8'h00, 8'h00, model(burst[i], 8'h00, 8'h00));
            cfg_commit = 1'b0;
            cfg_we = 1'b0;
            if (i > 3) chk("busy_in_burst", 64'(cfg_busy), 64'd1);
        end
        tick();
        chk("busy_drain", 64'(cfg_busy), 64'd1);
        tick();
        chk("busy_after_idle", 64'(cfg_busy), 64'd0);
        for (int i = 0; i < 8; i++) begin
            m_match[i] = s_match[i]; m_mmask[i] = s_mmask[i]; m_pbase[i] = s_pbase[i];
            m_pmask[i] = s_pmask[i]; m_attr[i]  = s_attr[i];
        end
        send(24'h700010, 8'h00, 8'h00, mk(0, 5, 24'h0A0010, 1, 0, 1, 0, 0, 0, 0));
        send(24'h01FFFF, 8'h00, 8'h00, model(24'h01FFFF, 8'h00, 8'h00));
        tick();
        tick();

        // Reset one cycle after a request drops it and clears everything.
        SNES_REQ = 1'b1; SNES_ADDR = 24'h002003; SNES_PA = 8'h3f; featurebits = 8'h18;
        tick();
        SNES_REQ = 1'b0;
        RST_N = 1'b0;
        last = '0;
        tick();
        chk("reset_valid", 64'(MAP_VALID), 64'd0);
        RST_N = 1'b1;
        tick();
        tick();
        send(24'h01FFFF, 8'h00, 8'h00, mk(1, 0, 24'h01FFFF, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
